// File: rtl/fpu_sched.sv
// fpu_sched: round-robin front end for two requesters sharing one
// fixed-latency FPU, returning tagged responses in acceptance order.
module fpu_sched #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [1:0]  req0_rmode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [1:0]  req1_rmode,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [2:0]  fpu_op,
  output logic [1:0]  fpu_rmode,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_out,
  input  logic [7:0]  fpu_flags,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [7:0]  rsp_flags,
  output logic        busy
);

  localparam int DEPTH = LATENCY + 1;
  localparam logic [31:0] QNAN_DATA  = 32'h7FC0_0000;
  localparam logic [7:0]  QNAN_FLAGS = 8'b0010_0000;

  typedef struct packed {
    logic vld;
    logic id;
    logic ill;
  } tag_t;

  tag_t [DEPTH-1:0] tag_q, tag_d;
  tag_t             exit_tag;

  logic        last_q, last_d;
  logic [2:0]  fpu_op_q, fpu_op_d;
  logic [1:0]  fpu_rmode_q, fpu_rmode_d;
  logic [31:0] fpu_a_q, fpu_a_d;
  logic [31:0] fpu_b_q, fpu_b_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [7:0]  rsp_flags_q, rsp_flags_d;
  logic        busy_q, busy_d;

  logic        grant0, grant1;
  logic        acc, sel, ill, issue;
  logic [2:0]  sel_op;
  logic [1:0]  sel_rmode;
  logic [31:0] sel_a, sel_b;
  logic        pipe_busy;

  // last_q names the requester granted most recently; the other wins a tie
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01: grant0 = 1'b1;
      2'b10: grant1 = 1'b1;
      2'b11: begin
        grant0 = last_q;
        grant1 = ~last_q;
      end
      default: ;
    endcase
  end

  assign req0_ready = en & req0_valid & grant0 & ~rst;
  assign req1_ready = en & req1_valid & grant1 & ~rst;

  always_comb begin
    acc       = req0_ready | req1_ready;
    sel       = req1_ready;
    sel_op    = sel ? req1_op    : req0_op;
    sel_rmode = sel ? req1_rmode : req0_rmode;
    sel_a     = sel ? req1_a     : req0_a;
    sel_b     = sel ? req1_b     : req0_b;
    ill       = acc & sel_op[2];
    issue     = acc & ~sel_op[2];
  end

  always_comb begin
    last_d      = acc ? sel : last_q;
    fpu_op_d    = issue ? sel_op : 3'd0;
    fpu_a_d     = issue ? sel_a : 32'd0;
    fpu_b_d     = issue ? sel_b : 32'd0;
    fpu_rmode_d = acc ? sel_rmode : fpu_rmode_q;

    tag_d[0] = '{vld: acc, id: sel, ill: ill};
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    pipe_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pipe_busy = pipe_busy | tag_d[i].vld;
    end
  end

  // tag leaving the last stage lines up with its FPU result on fpu_out
  always_comb begin
    exit_tag    = tag_q[DEPTH-1];
    rsp_valid_d = exit_tag.vld;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    if (exit_tag.vld) begin
      rsp_id_d    = exit_tag.id;
      rsp_data_d  = exit_tag.ill ? QNAN_DATA : fpu_out;
      rsp_flags_d = exit_tag.ill ? QNAN_FLAGS : fpu_flags;
    end
    busy_d = pipe_busy | rsp_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q       <= '0;
      last_q      <= 1'b1;
      fpu_op_q    <= 3'd0;
      fpu_rmode_q <= 2'd0;
      fpu_a_q     <= 32'd0;
      fpu_b_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_flags_q <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      last_q      <= last_d;
      fpu_op_q    <= fpu_op_d;
      fpu_rmode_q <= fpu_rmode_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      busy_q      <= busy_d;
    end
  end

  assign fpu_op    = fpu_op_q;
  assign fpu_rmode = fpu_rmode_q;
  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: randomized and directed checks of fpu_sched against
// an in-order response queue model and a behavioural FPU stub.
module tb_fpu_sched;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op, fpu_op;
  logic [1:0]  req0_rmode, req1_rmode, fpu_rmode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, fpu_a, fpu_b;
  logic [31:0] fpu_out, rsp_data;
  logic [7:0]  fpu_flags, rsp_flags;
  logic        rsp_valid, rsp_id, busy;

  fpu_sched #(.LATENCY(L)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_rmode(req0_rmode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_rmode(req1_rmode),
    .req1_a(req1_a), .req1_b(req1_b),
    .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] due;
    logic        id;
    logic [31:0] d;
    logic [7:0]  f;
  } rsp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  rsp_t exp_q[$];
  rsp_t obs_q[$];
  bit   last_m;
  int   last_due;

  logic        rd0, rd1, er0, er1, ef_leg, b_obs, b_exp;
  logic [2:0]  ef_op, f_op;
  logic [1:0]  ef_rm, f_rm;
  logic [31:0] ef_a, ef_b, f_a, f_b;

  // stand-in FPU: fixed pseudo-results, real 1.0+2.0, divide-by-zero flag
  function automatic logic [39:0] fpu_fn(logic [2:0] op, logic [31:0] a,
                                         logic [31:0] b);
    logic [31:0] d;
    logic [7:0]  f;
    if (op == 3'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) begin
      d = 32'h4040_0000;
      f = 8'h00;
    end else if (op == 3'd3 && b[30:0] == 31'd0) begin
      d = {a[31] ^ b[31], 8'hFF, 23'd0};
      f = 8'b1000_0001;
    end else begin
      d = a ^ {b[15:0], b[31:16]} ^ {29'd0, op};
      f = {a[7:3], op} & 8'hFE;
    end
    return {f, d};
  endfunction

  logic [39:0] fpu_pipe [L];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_fn(fpu_op, fpu_a, fpu_b);
    for (int i = 1; i < L; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign {fpu_flags, fpu_out} = fpu_pipe[L-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rsp_valid) obs_q.push_back('{cyc, rsp_id, rsp_data, rsp_flags});

  task automatic model_reset();
    exp_q.delete();
    last_m = 1'b1;
    last_due = -1;
  endtask

  // one clock: predict the grant, log the expected response, step the edge
  task automatic tick();
    bit          g1, ill;
    logic [2:0]  op;
    logic [1:0]  rm;
    logic [31:0] a, b;
    rsp_t        e;
    #1;
    g1  = (req0_valid && req1_valid) ? !last_m : req1_valid;
    er0 = en && req0_valid && !g1;
    er1 = en && req1_valid && g1;
    rd0 = req0_ready;
    rd1 = req1_ready;
    ef_op = 3'd0; ef_a = 32'd0; ef_b = 32'd0; ef_leg = 1'b0; ef_rm = 2'd0;
    if (er0 || er1) begin
      op  = er1 ? req1_op : req0_op;
      rm  = er1 ? req1_rmode : req0_rmode;
      a   = er1 ? req1_a : req0_a;
      b   = er1 ? req1_b : req0_b;
      ill = (op > 3'd3);
      e.due = cyc + L + 2;
      e.id  = er1;
      {e.f, e.d} = ill ? {8'h20, 32'h7FC0_0000} : fpu_fn(op, a, b);
      exp_q.push_back(e);
      last_m   = er1;
      last_due = cyc + L + 2;
      if (!ill) begin
        ef_op = op; ef_a = a; ef_b = b; ef_rm = rm; ef_leg = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    f_op = fpu_op; f_a = fpu_a; f_b = fpu_b; f_rm = fpu_rmode;
    b_obs = busy;
    b_exp = (cyc <= last_due);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_flags, fpu_op, fpu_rmode,
         fpu_a, fpu_b, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {rsp_valid, rsp_id,
               rsp_data, rsp_flags, fpu_op, fpu_rmode, fpu_a, fpu_b, busy});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b rsp_valid=%b want 0 0",
               busy, rsp_valid);
    end
  endtask

  task automatic test_contention();
    bit [3:0] seq = 4'b1010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_op = 3'($urandom_range(0, 3)); req1_op = 3'($urandom_range(0, 3));
      req0_a = $urandom; req0_b = $urandom;
      req1_a = $urandom; req1_b = $urandom;
      tick();
      checks++;
      if (rd1 !== seq[i] || rd0 !== !seq[i]) begin
        errors++;
        $display("FAIL contention_grant%0d: got %b%b want %b%b",
                 i, rd1, rd0, seq[i], !seq[i]);
      end
      checks++;
      if (f_op !== ef_op || f_a !== ef_a || f_b !== ef_b) begin
        errors++;
        $display("FAIL contention_issue%0d: got %h %h %h want %h %h %h",
                 i, f_op, f_a, f_b, ef_op, ef_a, ef_b);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (L + 3) tick();
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].id !== seq[i]) begin
        errors++;
        $display("FAIL contention_id%0d: got %b want %b", i, obs_q[i].id, seq[i]);
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL contention_count: got %0d want %0d",
               obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL contention_rsp%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_single();
    int acc;
    req0_valid = 1'b1; req0_op = 3'd0; req0_rmode = 2'd2;
    req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
    tick();
    acc = cyc;
    req0_valid = 1'b0;
    checks++;
    if (rd0 !== 1'b1 || f_op !== 3'd0 || f_a !== 32'h3F80_0000 ||
        f_b !== 32'h4000_0000 || f_rm !== 2'd2) begin
      errors++;
      $display("FAIL single_issue: got rdy=%b %h %h %h %h want 1 0 3f800000 40000000 2",
               rd0, f_op, f_a, f_b, f_rm);
    end
    repeat (L + 3) tick();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].due != acc + L + 1 || obs_q[0].id !== 1'b0 ||
        obs_q[0].d !== 32'h4040_0000) begin
      errors++;
      $display("FAIL single_rsp: got n=%0d %h want 1 edge %0d id 0 data 40400000",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0, acc + L + 1);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h4040_0000) begin
      errors++;
      $display("FAIL single_hold: got %b %h want 0 40400000", rsp_valid, rsp_data);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_rsp%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_illegal();
    int acc;
    req1_valid = 1'b1; req1_op = 3'd5; req1_rmode = 2'd1;
    req1_a = $urandom; req1_b = $urandom;
    tick();
    acc = cyc;
    req1_valid = 1'b0;
    checks++;
    if (rd1 !== 1'b1 || f_op !== 3'd0 || f_a !== 32'd0 || f_b !== 32'd0) begin
      errors++;
      $display("FAIL illegal_issue: got rdy=%b %h %h %h want 1 0 0 0",
               rd1, f_op, f_a, f_b);
    end
    repeat (L + 3) tick();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].due != acc + L + 1 || obs_q[0].id !== 1'b1 ||
        obs_q[0].d !== 32'h7FC0_0000 || obs_q[0].f !== 8'h20) begin
      errors++;
      $display("FAIL illegal_rsp: got n=%0d %h want edge %0d id 1 7fc00000 20",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0, acc + L + 1);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_divzero();
    req0_valid = 1'b1; req0_op = 3'd3;
    req0_a = 32'h3F80_0000; req0_b = 32'd0;
    tick();
    req0_valid = 1'b0;
    repeat (L + 3) tick();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].f[0] !== 1'b1) begin
      errors++;
      $display("FAIL divzero_flag: got n=%0d %h want flags bit0 set",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL divzero_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL divzero_rsp%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_drain();
    en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = 3'd2; req1_op = 3'd1;
    repeat (3) begin
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rd0 !== 1'b0 || rd1 !== 1'b0) begin
        errors++;
        $display("FAIL drain_ready%0d: got %b%b want 00", i, rd0, rd1);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < L + 2; i++) begin
      tick();
      checks++;
      if (b_obs !== b_exp) begin
        errors++;
        $display("FAIL drain_busy%0d: got %b want %b", i, b_obs, b_exp);
      end
    end
    checks++;
    if (obs_q.size() != 3 || exp_q.size() != 3) begin
      errors++;
      $display("FAIL drain_count: got %0d want 3", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL drain_rsp%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    en = 1'b1;
  endtask

  task automatic test_reset_midflight();
    req0_valid = 1'b1; req0_op = 3'd0;
    req0_a = $urandom; req0_b = $urandom;
    tick();
    req0_valid = 1'b0;
    repeat (2) tick();
    #1;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_flags, fpu_op, fpu_rmode,
         fpu_a, fpu_b, busy} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h want 0", {rsp_valid, rsp_id,
               rsp_data, rsp_flags, fpu_op, fpu_rmode, fpu_a, fpu_b, busy});
    end
    #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    model_reset();
    repeat (L + 3) tick();
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_discard: got %0d rsp want 0", obs_q.size());
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (rd0 !== 1'b1 || rd1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_grant: got %b%b want 01", rd1, rd0);
    end
    repeat (L + 3) tick();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_rsp%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      en = ($urandom_range(0, 7) != 0);
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_op = 3'($urandom_range(0, 7)); req1_op = 3'($urandom_range(0, 7));
      req0_rmode = 2'($urandom); req1_rmode = 2'($urandom);
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      tick();
      checks++;
      if (rd0 !== er0 || rd1 !== er1 || b_obs !== b_exp) begin
        errors++;
        $display("FAIL random_ctl%0d: got rdy=%b%b busy=%b want %b%b %b",
                 i, rd1, rd0, b_obs, er1, er0, b_exp);
      end
      checks++;
      if (f_op !== ef_op || f_a !== ef_a || f_b !== ef_b ||
          (ef_leg && f_rm !== ef_rm)) begin
        errors++;
        $display("FAIL random_issue%0d: got %h %h %h %h want %h %h %h %h",
                 i, f_op, f_a, f_b, f_rm, ef_op, ef_a, ef_b, ef_rm);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < L + 3; i++) begin
      tick();
      checks++;
      if (b_obs !== b_exp) begin
        errors++;
        $display("FAIL random_busy%0d: got %b want %b", i, b_obs, b_exp);
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_rsp%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_rmode = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_rmode = '0; req1_a = '0; req1_b = '0;
    model_reset();
    test_reset();
    test_contention();
    test_single();
    test_illegal();
    test_divzero();
    test_drain();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_sched.md
FPU_SCHED -- requirements
Module: fpu_sched

Interface
REQ-001 SHALL have parameter LATENCY, default 4: FPU clock edges from operands applied on fpu_a/fpu_b to a valid fpu_out/fpu_flags.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port en, input, 1; when 0, no new request is granted.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 each, request present.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 each, request accepted this cycle.
REQ-007 SHALL have ports reqN_op, input, 3, FPU opcode per requester (0 add, 1 sub, 2 mul, 3 div, 4-7 illegal).
REQ-008 SHALL have ports reqN_rmode, input, 2, rounding mode per requester.
REQ-009 SHALL have ports reqN_a/reqN_b, input, 32 each, operands per requester.
REQ-010 SHALL have ports fpu_op (3), fpu_rmode (2), fpu_a (32), fpu_b (32), all registered outputs to the shared FPU.
REQ-011 SHALL have ports fpu_out, input, 32, and fpu_flags, input, 8, ordered {inf,snan,qnan,ine,overflow,underflow,zero,div_by_zero}.
REQ-012 SHALL have ports rsp_valid (1), rsp_id (1), rsp_data (32) and rsp_flags (8), all registered outputs.
REQ-013 SHALL have port busy, output, 1, high while any accepted operation has not yet produced rsp_valid.

Function
REQ-014 SHALL compute readiness combinationally: reqN_ready = en & reqN_valid & grantN; at most one ready per cycle.
REQ-015 SHALL arbitrate round-robin: with one valid, grant it; with both valid, grant the one not granted last; last-grant pointer updates only on acceptance.
REQ-016 SHALL accept a request (valid & ready at a rising edge) by registering op, rmode, a and b into fpu_* on that edge, and by entering tag {valid=1, id, illegal} into a LATENCY+1-deep tag shift register.
REQ-017 SHALL drive fpu_op=0, fpu_a=0, fpu_b=0 on edges with no acceptance, and SHALL hold fpu_rmode.
REQ-018 SHALL issue at most one operation per cycle, back-to-back with no bubbles; no backpressure exists on rsp_*.
REQ-019 SHALL register rsp_valid=1, rsp_id=tag id, rsp_data=fpu_out and rsp_flags=fpu_flags on the edge at which the tag exits, which is accept edge + LATENCY + 1.
REQ-020 SHALL pulse rsp_valid for exactly one cycle per accepted request; rsp_data/rsp_flags hold their last value while rsp_valid=0.
REQ-021 SHALL accept an illegal op (4-7) without issuing it to the FPU (fpu_op=0, operands 0), and SHALL return it at the same latency with rsp_data=32'h7FC00000 and rsp_flags=8'b00100000.
REQ-022 SHALL let all in-flight operations complete normally when en is deasserted; busy falls on the edge after the last rsp_valid is registered.
REQ-023 SHALL keep responses in acceptance order, independent of requester.

Reset
REQ-024 SHALL, on rst=1 (asynchronous), clear the tag pipe, set rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0, fpu_op=0, fpu_rmode=0, fpu_a=0, fpu_b=0 and busy=0, and set the last-grant pointer to 1 so that requester 0 wins first.
REQ-025 SHALL discard operations in flight at reset, producing no rsp_valid for them; reqN_ready=0 while rst=1.

Verification
REQ-026 SHALL be verified for single issue: LATENCY=4, req0 add a=32'h3F800000 b=32'h40000000 accepted at edge 10 -> fpu_op=0 after edge 10; rsp_valid high after edge 15 only, rsp_id=0, rsp_data=32'h40400000.
REQ-027 SHALL be verified for contention: both valid continuously for 4 cycles after reset -> grants 0,1,0,1 and rsp_id sequence 0,1,0,1 on 4 consecutive cycles.
REQ-028 SHALL be verified for illegal op: req1 op=5 -> fpu_op stays 0, rsp_id=1, rsp_data=32'h7FC00000, rsp_flags=8'h20 at nominal latency.
REQ-029 SHALL be verified for drain: en dropped one cycle after 3 back-to-back accepts -> no further ready, 3 rsp_valid pulses, busy low on the edge after the third.
REQ-030 SHALL be verified for reset mid-flight: rst pulsed 2 cycles after an accept -> no rsp_valid for that op, all outputs 0, and the next accept with both valid grants req0.
REQ-031 SHALL be verified for div-by-zero passthrough: div a=32'h3F800000 b=0 -> rsp_flags bit0=1 and rsp_data equal to fpu_out.
